// File: rtl/prm_oblgc_sched.sv
// Sequencer for the PRM obstacle-check bank: streams voxel codes into the grouped
// edge checkers and ORs every returned edge_mask group into a readable bitmap.
module prm_oblgc_sched #(
    parameter int CODE_W    = 15,
    parameter int NUM_EDGES = 1024,
    parameter int BANK_W    = 64,
    parameter int CHK_LAT   = 1,
    localparam int NUM_GRP  = NUM_EDGES / BANK_W,
    localparam int GRP_W    = $clog2(NUM_GRP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code,
    input  logic              code_last,
    output logic [CODE_W-1:0] chk_code,
    output logic [GRP_W-1:0]  chk_grp,
    input  logic [BANK_W-1:0] chk_mask,
    output logic              busy,
    output logic              done,
    output logic [15:0]       voxel_cnt,
    input  logic [GRP_W-1:0]  rd_addr,
    output logic [BANK_W-1:0] rd_data
);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT, SCAN, DRAIN, DONE} state_t;

    localparam logic [GRP_W-1:0]   GRP_LAST = GRP_W'(NUM_GRP - 1);
    // Every pipeline stage except the one retiring this cycle.
    localparam logic [CHK_LAT-1:0] UP_MASK  = {CHK_LAT{1'b1}} >> 1;

    state_t              state_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                last_q;
    logic [CODE_W-1:0]   code_q;
    logic [GRP_W-1:0]    grp_q;
    logic [GRP_W-1:0]    clr_q;
    logic [15:0]         vcnt_q;
    logic [CHK_LAT-1:0]  vld_p_q;
    logic [GRP_W-1:0]    idx_p_q [CHK_LAT];
    logic [BANK_W-1:0]   bitmap_q [NUM_GRP];
    logic [BANK_W-1:0]   rd_data_q;

    logic                pipe_busy;
    logic                cap_we;
    logic                clr_we;
    logic [GRP_W-1:0]    cap_idx;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pipe_busy = |(vld_p_q & UP_MASK);
    assign cap_we    = vld_p_q[CHK_LAT-1] && !abort;
    assign cap_idx   = idx_p_q[CHK_LAT-1];
    assign clr_we    = (state_q == CLEAR) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            code_q  <= '0;
            grp_q   <= '0;
            clr_q   <= '0;
            vcnt_q  <= '0;
            vld_p_q <= '0;
            for (int i = 0; i < CHK_LAT; i++) begin
                idx_p_q[i] <= '0;
            end
        end else if (abort) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_p_q <= '0;
        end else begin
            // Checker latency pipeline: group index issued in SCAN, retired CHK_LAT cycles later
            vld_p_q[0] <= (state_q == SCAN);
            idx_p_q[0] <= grp_q;
            for (int i = 1; i < CHK_LAT; i++) begin
                vld_p_q[i] <= vld_p_q[i-1];
                idx_p_q[i] <= idx_p_q[i-1];
            end

            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        vcnt_q  <= '0;
                        clr_q   <= '0;
                    end
                end
                CLEAR: begin
                    clr_q <= clr_q + GRP_W'(1);
                    if (clr_q == GRP_LAST) begin
                        state_q <= WAIT;
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (code_valid) begin
                        code_q  <= code;
                        last_q  <= code_last;
                        vcnt_q  <= sat_inc16(vcnt_q);
                        grp_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (grp_q == GRP_LAST) begin
                        state_q <= DRAIN;
                    end else begin
                        grp_q <= grp_q + GRP_W'(1);
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        if (last_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bitmap storage: sequential clear, OR capture at pipeline exit, registered read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_GRP; k++) begin
                bitmap_q[k] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            rd_data_q <= bitmap_q[rd_addr];
            if (clr_we) begin
                bitmap_q[clr_q] <= '0;
            end else if (cap_we) begin
                bitmap_q[cap_idx] <= bitmap_q[cap_idx] | chk_mask;
            end
        end
    end

    assign code_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign chk_code   = code_q;
    assign chk_grp    = grp_q;
    assign voxel_cnt  = vcnt_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_prm_oblgc_sched.sv
// Bench for prm_oblgc_sched: two instances (checker latency 1 and 3) driven by
// directed and random voxel frames, checked against a per-edge bitmap model.
`timescale 1ns/1ps
module tb_prm_oblgc_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        start_s, abort_s, cv_s, last_s;
    logic [1:0][14:0]  code_s;
    logic [1:0][3:0]   rda_s;
    logic [1:0]        ready_s, busy_s, done_s;
    logic [1:0][14:0]  chkc_s;
    logic [1:0][3:0]   grp_s;
    logic [1:0][63:0]  mask_s;
    logic [1:0][15:0]  vcnt_s;
    logic [1:0][63:0]  rdd_s;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_bm [2][16];
    int          exp_cnt [2];

    // Environment: which edges a voxel code blocks. 0x7xxx codes block only edge code[9:0].
    function automatic bit edge_hit(input logic [14:0] c, input int e);
        logic [31:0] h;
        if (c[14:12] == 3'b111) return (e == int'(c[9:0]));
        h = (32'(c) * 32'h9E3779B1) ^ (32'(e) * 32'h85EBCA6B);
        h = h ^ (h >> 15);
        h = h * 32'h2C1B3C6D;
        return (h[31:28] == 4'h0);
    endfunction

    function automatic logic [63:0] bank_mask(input logic [14:0] c, input logic [3:0] g);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = edge_hit(c, int'(g) * 64 + i);
        return m;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [63:0] dly [LAT];

        prm_oblgc_sched #(.CODE_W(15), .NUM_EDGES(1024), .BANK_W(64), .CHK_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst), .start(start_s[g]), .abort(abort_s[g]),
            .code_valid(cv_s[g]), .code_ready(ready_s[g]), .code(code_s[g]),
            .code_last(last_s[g]), .chk_code(chkc_s[g]), .chk_grp(grp_s[g]),
            .chk_mask(mask_s[g]), .busy(busy_s[g]), .done(done_s[g]),
            .voxel_cnt(vcnt_s[g]), .rd_addr(rda_s[g]), .rd_data(rdd_s[g]));

        always @(posedge clk) begin
            dly[0] <= bank_mask(chkc_s[g], grp_s[g]);
            for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
        assign mask_s[g] = dly[LAT-1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input int u);
        for (int w = 0; w < 16; w++) exp_bm[u][w] = '0;
        exp_cnt[u] = 0;
    endtask

    task automatic model_accept(input int u, input logic [14:0] c, input bit upd);
        if (upd)
            for (int e = 0; e < 1024; e++)
                if (edge_hit(c, e)) exp_bm[u][e / 64][e % 64] = 1'b1;
        if (exp_cnt[u] < 65535) exp_cnt[u]++;
    endtask

    task automatic do_start(input int u);
        start_s[u] = 1'b1;
        tick(1);
        start_s[u] = 1'b0;
        model_clear(u);
    endtask

    task automatic wait_ready(input int u, output int n);
        n = 0;
        while (ready_s[u] !== 1'b1 && n < 300) begin tick(1); n++; end
        check($sformatf("u%0d_ready_timeout", u), 64'(n < 300), 64'(1));
    endtask

    task automatic wait_done(input int u, output int n);
        n = 0;
        while (done_s[u] !== 1'b1 && n < 300) begin tick(1); n++; end
        check($sformatf("u%0d_done_timeout", u), 64'(n < 300), 64'(1));
    endtask

    // Offers a code and returns the cycle number of the accepting edge; valid stays high.
    task automatic send(input int u, input logic [14:0] c, input logic l, input bit upd,
                        output int acc);
        int n;
        code_s[u] = c;
        last_s[u] = l;
        cv_s[u]   = 1'b1;
        wait_ready(u, n);
        tick(1);
        acc = cyc;
        model_accept(u, c, upd);
        check($sformatf("u%0d_ready_one_cycle", u), 64'(ready_s[u]), 64'(0));
    endtask

    task automatic read_word(input int u, input int a, output logic [63:0] d);
        rda_s[u] = 4'(a);
        tick(1);
        d = rdd_s[u];
    endtask

    task automatic check_bitmap(input int u, input string tag);
        logic [63:0] d;
        for (int w = 0; w < 16; w++) begin
            read_word(u, w, d);
            check($sformatf("%s_w%0d", tag, w), d, exp_bm[u][w]);
        end
    endtask

    task automatic rand_frame(input int u, input int nv, input string tag);
        int n, acc;
        logic [14:0] c, prev;
        int r;
        prev = '0;
        acc  = 0;
        for (int i = 0; i < nv; i++) begin
            cv_s[u] = 1'b0;
            tick($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 3)             c = 15'h7000 | 15'($urandom_range(0, 1023));
            else if (r < 5 && i > 0) c = prev;
            else                   c = 15'($urandom_range(0, 15'h6FFF));
            prev = c;
            send(u, c, (i == nv - 1), 1'b1, acc);
        end
        cv_s[u] = 1'b0;
        wait_done(u, n);
        check({tag, "_done_lat"}, 64'(cyc - acc), 64'(16 + lat_of(u)));
        check({tag, "_busy"}, 64'(busy_s[u]), 64'(0));
        check({tag, "_vcnt"}, 64'(vcnt_s[u]), 64'(exp_cnt[u]));
        check_bitmap(u, tag);
    endtask

    initial begin
        int n, a, a_prev, e0, e;
        logic [63:0] d;
        logic [14:0] c1;

        rst = 1'b1;
        start_s = '0; abort_s = '0; cv_s = '0; last_s = '0; code_s = '0; rda_s = '0;
        model_clear(0);
        model_clear(1);
        tick(3);

        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_rst_ready", u), 64'(ready_s[u]), 64'(0));
            check($sformatf("u%0d_rst_busy", u),  64'(busy_s[u]),  64'(0));
            check($sformatf("u%0d_rst_done", u),  64'(done_s[u]),  64'(0));
            check($sformatf("u%0d_rst_chkc", u),  64'(chkc_s[u]),  64'(0));
            check($sformatf("u%0d_rst_grp", u),   64'(grp_s[u]),   64'(0));
            check($sformatf("u%0d_rst_vcnt", u),  64'(vcnt_s[u]),  64'(0));
            check($sformatf("u%0d_rst_rdd", u),   rdd_s[u],        64'(0));
        end
        rst = 1'b0;
        tick(2);

        // Asynchronous reset in the middle of a scan
        do_start(0);
        send(0, 15'h4A51, 1'b1, 1'b1, a);
        cv_s[0] = 1'b0;
        n = 0;
        while (grp_s[0] !== 4'd7 && n < 50) begin tick(1); n++; end
        check("t1_grp7_timeout", 64'(n < 50), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t1_async_ready", 64'(ready_s[0]), 64'(0));
        check("t1_async_busy",  64'(busy_s[0]),  64'(0));
        check("t1_async_done",  64'(done_s[0]),  64'(0));
        check("t1_async_chkc",  64'(chkc_s[0]),  64'(0));
        check("t1_async_grp",   64'(grp_s[0]),   64'(0));
        check("t1_async_vcnt",  64'(vcnt_s[0]),  64'(0));
        check("t1_async_rdd",   rdd_s[0],        64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);
        check("t1_idle_busy", 64'(busy_s[0]), 64'(0));
        model_clear(0);
        check_bitmap(0, "t1_bm");

        // Single voxel with the default latency; code offered already during CLEAR
        do_start(0);
        e0 = cyc;
        check("t2_busy", 64'(busy_s[0]), 64'(1));
        code_s[0] = 15'h4A51; last_s[0] = 1'b1; cv_s[0] = 1'b1;
        wait_ready(0, n);
        check("t2_ready_rise", 64'(cyc - e0), 64'(16));
        check("t2_cnt_before", 64'(vcnt_s[0]), 64'(0));
        tick(1);
        a = cyc;
        model_accept(0, 15'h4A51, 1'b1);
        cv_s[0] = 1'b0;
        check("t2_cnt_after", 64'(vcnt_s[0]), 64'(1));
        check("t2_ready_low", 64'(ready_s[0]), 64'(0));
        check("t2_chkc", 64'(chkc_s[0]), 64'(15'h4A51));
        wait_done(0, n);
        check("t2_done_lat", 64'(cyc - a), 64'(17));
        check("t2_busy_done", 64'(busy_s[0]), 64'(0));
        read_word(0, 3, d);
        check("t2_word3", d, exp_bm[0][3]);
        check_bitmap(0, "t2_bm");

        // Three voxels back to back, valid held high
        do_start(0);
        send(0, 15'h7005, 1'b0, 1'b1, a);
        a_prev = a;
        send(0, 15'h7005, 1'b0, 1'b1, a);
        check("t3_period1", 64'(a - a_prev), 64'(18));
        a_prev = a;
        send(0, 15'h73FF, 1'b1, 1'b1, a);
        check("t3_period2", 64'(a - a_prev), 64'(18));
        cv_s[0] = 1'b0;
        wait_done(0, n);
        check("t3_done_lat", 64'(cyc - a), 64'(17));
        check("t3_vcnt", 64'(vcnt_s[0]), 64'(3));
        read_word(0, 0, d);
        check("t3_word0", d, 64'h20);
        read_word(0, 15, d);
        check("t3_word15", d, 64'h8000_0000_0000_0000);
        check_bitmap(0, "t3_bm");

        // Second frame from DONE: counter reset, clear sequence, no acceptance during CLEAR
        do_start(0);
        e0 = cyc;
        check("t4_done_drop", 64'(done_s[0]), 64'(0));
        check("t4_busy", 64'(busy_s[0]), 64'(1));
        check("t4_vcnt_clr", 64'(vcnt_s[0]), 64'(0));
        code_s[0] = 15'h7005; last_s[0] = 1'b1; cv_s[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("t4_clear_vcnt%0d", i), 64'(vcnt_s[0]), 64'(0));
            check($sformatf("t4_clear_ready%0d", i), 64'(ready_s[0]), 64'(0));
        end
        cv_s[0] = 1'b0;
        wait_ready(0, n);
        check("t4_clear_len", 64'(cyc - e0), 64'(16));
        check_bitmap(0, "t4_cleared");
        check("t4_wait_ready", 64'(ready_s[0]), 64'(1));
        rand_frame(0, 4, "t4_rand");

        // Abort together with start on the cycle that retires group 9
        do_start(0);
        c1 = 15'($urandom_range(0, 15'h6FFF));
        send(0, c1, 1'b0, 1'b1, a);
        cv_s[0] = 1'b0;
        e = 576;
        for (int i = 63; i >= 0; i--) if (!edge_hit(c1, 576 + i)) e = 576 + i;
        send(0, 15'h7000 | 15'(e), 1'b1, 1'b0, a);
        cv_s[0] = 1'b0;
        n = 0;
        while (grp_s[0] !== 4'd10 && n < 50) begin tick(1); n++; end
        check("t5_grp10_timeout", 64'(n < 50), 64'(1));
        abort_s[0] = 1'b1; start_s[0] = 1'b1;
        tick(1);
        abort_s[0] = 1'b0; start_s[0] = 1'b0;
        check("t5_busy", 64'(busy_s[0]), 64'(0));
        check("t5_done", 64'(done_s[0]), 64'(0));
        check("t5_ready", 64'(ready_s[0]), 64'(0));
        check("t5_vcnt", 64'(vcnt_s[0]), 64'(2));
        tick(2);
        check("t5_stay_idle", 64'(busy_s[0]), 64'(0));
        read_word(0, 9, d);
        check("t5_word9", d, exp_bm[0][9]);
        check_bitmap(0, "t5_bm");
        do_start(0);
        e0 = cyc;
        wait_ready(0, n);
        check("t5_restart_clear_len", 64'(cyc - e0), 64'(16));
        check_bitmap(0, "t5_cleared");
        rand_frame(0, 3, "t5_rand");

        // Checker latency of three cycles
        do_start(1);
        e0 = cyc;
        wait_ready(1, n);
        check("t7_ready_rise", 64'(cyc - e0), 64'(16));
        send(1, 15'h7000 | 15'd581, 1'b1, 1'b1, a);
        cv_s[1] = 1'b0;
        wait_done(1, n);
        check("t7_done_lat", 64'(cyc - a), 64'(19));
        read_word(1, 9, d);
        check("t7_word9", d, 64'h20);
        read_word(1, 8, d);
        check("t7_word8", d, 64'h0);
        read_word(1, 10, d);
        check("t7_word10", d, 64'h0);
        do_start(1);
        wait_ready(1, n);
        rand_frame(1, 4, "t7_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
